radar_tx_arbiter: RTL and testbench



---
 rtl/radar_tx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_radar_tx_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/radar_tx_arbiter.sv
// Round-robin arbiter sharing one radar emitter/receiver between NREQ channels.
// Optional macro RADAR_ARB_PRIO0_EN gives channel 0 fixed top priority.
module radar_tx_arbiter #(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned PULSE_CYCLES  = 300,
  parameter int unsigned LISTEN_CYCLES = 2000,
  parameter int unsigned GUARD_CYCLES  = 10
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] req,
  input  logic            radar_echo,
  output logic [NREQ-1:0] gnt,
  output logic            radar_pulse_trigger,
  output logic [31:0]     echo_cycles,
  output logic            echo_hit,
  output logic            done,
  output logic [2:0]      done_id,
  output logic [1:0]      arb_state
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned SUM_W = IDX_W + 1;

  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LISTEN_LAST = CNT_W'(LISTEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [SUM_W-1:0] NREQ_S      = SUM_W'(NREQ);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EMIT   = 2'b01,
    LISTEN = 2'b10,
    GUARD  = 2'b11
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [IDX_W-1:0]  gnt_idx, gnt_idx_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic              trig_nxt;
  logic [CNT_W-1:0]  echo_cycles_nxt;
  logic              echo_hit_nxt;
  logic              done_nxt;
  logic [IDX_W-1:0]  done_id_nxt;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IDX_W-1:0]  rr_off;
  logic [SUM_W-1:0]  win_sum;
  logic [IDX_W-1:0]  win_idx;
  logic [SUM_W-1:0]  ptr_inc;
  logic              win_adv;

  // Rotate requests so ptr sits at bit 0; lowest set bit is the round-robin winner.
  always_comb begin
    req_dbl = {req, req};
    req_rot = NREQ'(req_dbl >> ptr);
    rr_off  = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_rot[i]) rr_off = IDX_W'(i);
    end
    win_sum = {1'b0, ptr} + SUM_W'(rr_off);
    if (win_sum >= NREQ_S) win_sum = win_sum - NREQ_S;
    win_idx = win_sum[IDX_W-1:0];
    win_adv = 1'b1;
`ifdef RADAR_ARB_PRIO0_EN
    if (req[0]) begin
      win_idx = '0;
      win_adv = 1'b0;
    end
`else
`endif
    ptr_inc = {1'b0, win_idx} + SUM_W'(1);
    if (ptr_inc >= NREQ_S) ptr_inc = '0;
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state               <= IDLE;
      cnt                 <= '0;
      ptr                 <= '0;
      gnt_idx             <= '0;
      gnt                 <= '0;
      radar_pulse_trigger <= 1'b0;
      echo_cycles         <= '0;
      echo_hit            <= 1'b0;
      done                <= 1'b0;
      done_id             <= '0;
    end else begin
      state               <= state_nxt;
      cnt                 <= cnt_nxt;
      ptr                 <= ptr_nxt;
      gnt_idx             <= gnt_idx_nxt;
      gnt                 <= gnt_nxt;
      radar_pulse_trigger <= trig_nxt;
      echo_cycles         <= echo_cycles_nxt;
      echo_hit            <= echo_hit_nxt;
      done                <= done_nxt;
      done_id             <= done_id_nxt;
    end
  end

  assign arb_state = state;

  // Next-state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = EMIT;
      EMIT:    if (cnt == PULSE_LAST) state_nxt = LISTEN;
      LISTEN:  if (radar_echo || (cnt == LISTEN_LAST)) state_nxt = GUARD;
      GUARD:   if (cnt == GUARD_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the counter, pointer and registered outputs
  always_comb begin
    cnt_nxt         = cnt + CNT_W'(1);
    ptr_nxt         = ptr;
    gnt_idx_nxt     = gnt_idx;
    gnt_nxt         = gnt;
    trig_nxt        = radar_pulse_trigger;
    echo_cycles_nxt = echo_cycles;
    echo_hit_nxt    = echo_hit;
    done_nxt        = 1'b0;
    done_id_nxt     = done_id;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (|req) begin
          gnt_nxt     = NREQ'(1) << win_idx;
          trig_nxt    = 1'b1;
          gnt_idx_nxt = win_idx;
          if (win_adv) ptr_nxt = ptr_inc[IDX_W-1:0];
        end
      end
      EMIT: begin
        if (cnt == PULSE_LAST) begin
          trig_nxt = 1'b0;
          cnt_nxt  = '0;
        end
      end
      LISTEN: begin
        // An echo on the final listen cycle takes precedence over timeout.
        if (radar_echo) begin
          echo_cycles_nxt = cnt;
          echo_hit_nxt    = 1'b1;
          done_nxt        = 1'b1;
          done_id_nxt     = gnt_idx;
          cnt_nxt         = '0;
        end else if (cnt == LISTEN_LAST) begin
          echo_cycles_nxt = '0;
          echo_hit_nxt    = 1'b0;
          done_nxt        = 1'b1;
          done_id_nxt     = gnt_idx;
          cnt_nxt         = '0;
        end
      end
      GUARD: begin
        if (cnt == GUARD_LAST) begin
          gnt_nxt = '0;
          cnt_nxt = '0;
        end
      end
      default: cnt_nxt = '0;
    endcase
  end

endmodule

// File: tb/tb_radar_tx_arbiter.sv
// Scoreboard bench for radar_tx_arbiter: stimulus queues expected grants and
// done records; a negedge monitor pops and compares them.
module tb_radar_tx_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned P    = 3;
  localparam int unsigned L    = 8;
  localparam int unsigned G    = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic            radar_echo = 1'b0;
  logic [NREQ-1:0] gnt;
  logic            radar_pulse_trigger;
  logic [31:0]     echo_cycles;
  logic            echo_hit;
  logic            done;
  logic [2:0]      done_id;
  logic [1:0]      arb_state;

  radar_tx_arbiter #(
    .NREQ(NREQ), .PULSE_CYCLES(P), .LISTEN_CYCLES(L), .GUARD_CYCLES(G)
  ) dut (
    .CLK(CLK), .RST(RST), .req(req), .radar_echo(radar_echo), .gnt(gnt),
    .radar_pulse_trigger(radar_pulse_trigger), .echo_cycles(echo_cycles),
    .echo_hit(echo_hit), .done(done), .done_id(done_id), .arb_state(arb_state)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]  id;
    logic        hit;
    logic [31:0] cyc;
  } done_t;

  done_t           dq[$];
  logic [NREQ-1:0] gq[$];
  int              n_chk  = 0;
  int              n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Monitor: grants, pulse width and done records against the queues
  done_t           exp_d;
  logic [NREQ-1:0] prev_gnt = '0;
  int              tcnt = 0;
  always @(negedge CLK) begin
    if (RST) begin
      prev_gnt = '0;
      tcnt     = 0;
    end else begin
      if (done) begin
        if (dq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: done_id=%0d with nothing expected", done_id);
        end else begin
          exp_d = dq.pop_front();
          chk("done_id", 32'(done_id), 32'(exp_d.id));
          chk("echo_hit", 32'(echo_hit), 32'(exp_d.hit));
          chk("echo_cycles", echo_cycles, exp_d.cyc);
        end
      end
      if (gnt != '0 && prev_gnt == '0) begin
        if (gq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_grant: gnt=0x%0h with nothing expected", gnt);
        end else begin
          chk("grant", 32'(gnt), 32'(gq.pop_front()));
          chk("trigger_at_grant", 32'(radar_pulse_trigger), 32'd1);
        end
      end
      if (radar_pulse_trigger) tcnt++;
      else if (tcnt != 0) begin
        chk("pulse_len", 32'(tcnt), 32'(P));
        tcnt = 0;
      end
      prev_gnt = gnt;
    end
  end

  task automatic wait_state(input logic [1:0] s, input string nm, output int k);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (arb_state !== s && k < 100);
    if (arb_state !== s) begin
      n_chk++;
      $display("FAIL wait_%s: arb_state=%0d never reached %0d", nm, arb_state, s);
    end
  endtask

  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (done !== 1'b1 && k < 100);
    if (done !== 1'b1) begin
      n_chk++;
      $display("FAIL wait_done: done=%0b never asserted", done);
    end
  endtask

  // Pulse the echo during the LISTEN cycle whose count is n (called at first LISTEN negedge)
  task automatic echo_at(input int n);
    repeat (n) @(posedge CLK);
    #1 radar_echo = 1'b1;
    @(posedge CLK);
    #1 radar_echo = 1'b0;
  endtask

  task automatic expect_txn(input logic [NREQ-1:0] g, input logic [2:0] id,
                            input logic hit, input logic [31:0] cyc);
    done_t d;
    d.id  = id;
    d.hit = hit;
    d.cyc = cyc;
    gq.push_back(g);
    dq.push_back(d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int order[5];

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_trigger", 32'(radar_pulse_trigger), 32'd0);
    chk("rst_echo_cycles", echo_cycles, 32'd0);
    chk("rst_echo_hit", 32'(echo_hit), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_state", 32'(arb_state), 32'd0);
    RST = 1'b0;

    // Fairness: all four requesting, every transaction times out
`ifdef RADAR_ARB_PRIO0_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    for (int t = 0; t < 5; t++)
      expect_txn(NREQ'(1) << order[t], 3'(order[t]), 1'b0, 32'd0);
    @(negedge CLK);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) wait_done(k);
    req = '0;
    wait_state(2'b00, "idle", k);

    // Single request with echo four cycles into LISTEN
    expect_txn(4'b0001, 3'd0, 1'b1, 32'd4);
    req = 4'b0001;
    wait_state(2'b01, "emit", k);
    wait_state(2'b10, "listen", k);
    echo_at(4);
    wait_done(k);
    req = '0;
    wait_state(2'b00, "idle", k);

    // Timeout: done after L listen cycles, IDLE G cycles after done
    expect_txn(4'b0010, 3'd1, 1'b0, 32'd0);
    req = 4'b0010;
    wait_state(2'b01, "emit", k);
    wait_state(2'b10, "listen", k);
    wait_done(k);
    chk("listen_len", 32'(k), 32'(L));
    req = '0;
    wait_state(2'b00, "idle", k);
    chk("guard_len", 32'(k), 32'(G));

    // Request dropped during EMIT still completes
    expect_txn(4'b1000, 3'd3, 1'b0, 32'd0);
    req = 4'b1000;
    wait_state(2'b01, "emit", k);
    req = '0;
    wait_done(k);
    wait_state(2'b00, "idle", k);

    // Echoes in EMIT and GUARD ignored; echo on last LISTEN cycle wins
    expect_txn(4'b0100, 3'd2, 1'b1, 32'd7);
    req = 4'b0100;
    wait_state(2'b01, "emit", k);
    radar_echo = 1'b1;
    @(negedge CLK);
    radar_echo = 1'b0;
    wait_state(2'b10, "listen", k);
    echo_at(7);
    wait_done(k);
    radar_echo = 1'b1;
    req = '0;
    wait_state(2'b00, "idle", k);
    radar_echo = 1'b0;

    // Reset on second LISTEN cycle aborts without done
    gq.push_back(4'b0001);
    req = 4'b0001;
    wait_state(2'b01, "emit", k);
    wait_state(2'b10, "listen", k);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("mrst_gnt", 32'(gnt), 32'd0);
    chk("mrst_trigger", 32'(radar_pulse_trigger), 32'd0);
    chk("mrst_echo_cycles", echo_cycles, 32'd0);
    chk("mrst_echo_hit", 32'(echo_hit), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_done_id", 32'(done_id), 32'd0);
    chk("mrst_state", 32'(arb_state), 32'd0);
    req = '0;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);

    expect_txn(4'b0100, 3'd2, 1'b1, 32'd2);
    req = 4'b0100;
    wait_state(2'b01, "emit", k);
    wait_state(2'b10, "listen", k);
    echo_at(2);
    wait_done(k);
    req = '0;
    wait_state(2'b00, "idle", k);

    repeat (5) @(negedge CLK);
    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    chk("grant_queue_empty", 32'(gq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
